// File: rtl/nv_nvdla_pdp_rdma_burst_ig.sv
// PDP read-DMA ingress engine: walks one cube-read command line by line, splits
// each line into credit-gated bursts to MCIF or CVIF and pushes one context entry per burst.
module nv_nvdla_pdp_rdma_burst_ig #(
    parameter int AW             = 64,
    parameter int MAX_BURST      = 8,
    parameter int ATOM_BYTES     = 32,
    parameter int LAT_FIFO_DEPTH = 256
) (
    input  logic            nvdla_core_clk,
    input  logic            nvdla_core_rstn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [12:0]     cmd_line_num,
    input  logic [12:0]     cmd_line_atoms,
    input  logic [31:0]     cmd_line_stride,
    input  logic            cmd_ram_type,
    output logic            pdp2mcif_rd_req_valid,
    input  logic            pdp2mcif_rd_req_ready,
    output logic [AW+14:0]  pdp2mcif_rd_req_pd,
    output logic            pdp2cvif_rd_req_valid,
    input  logic            pdp2cvif_rd_req_ready,
    output logic [AW+14:0]  pdp2cvif_rd_req_pd,
    input  logic            mcif_cdt_pop,
    input  logic            cvif_cdt_pop,
    output logic            ig2cq_pvld,
    input  logic            ig2cq_prdy,
    output logic [5:0]      ig2cq_pd,
    output logic [31:0]     perf_read_stall,
    output logic            cdt_err,
    output logic            done
);

    localparam int CW  = 16;
    localparam int ASH = $clog2(ATOM_BYTES);
    localparam logic [CW-1:0] DEPTH_C = CW'(LAT_FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            ram_q;
    logic [12:0]     line_num_q;
    logic [12:0]     line_atoms_q;
    logic [31:0]     stride_q;
    logic [AW-1:0]   line_base_q;
    logic [12:0]     atom_off_q;
    logic [12:0]     line_idx_q;
    logic            all_cmt_q;
    logic            req_vld_q;
    logic [AW+14:0]  req_pd_q;
    logic [CW-1:0]   mc_cdt_q;
    logic [CW-1:0]   cv_cdt_q;
    logic [31:0]     perf_q;
    logic            err_q;

    logic [13:0]     rem_s;
    logic            line_end_s;
    logic [4:0]      size_s;
    logic [4:0]      size_m1_s;
    logic            last_line_s;
    logic            last_cube_s;
    logic [CW-1:0]   sel_cdt_s;
    logic            sel_rdy_s;
    logic            out_drain_s;
    logic            accept_s;
    logic            commit_s;
    logic [AW-1:0]   burst_addr_s;
    logic [CW-1:0]   mc_dec_s;
    logic [CW-1:0]   cv_dec_s;
    logic [CW:0]     mc_nxt_s;
    logic [CW:0]     cv_nxt_s;

    // Returns {overflow, next_count}; a pop that would exceed the FIFO depth is dropped and flagged.
    function automatic logic [CW:0] cdt_next(input logic [CW-1:0] cnt,
                                             input logic [CW-1:0] dec,
                                             input logic          pop);
        logic [CW-1:0] after;
        logic          ovf;
        after = cnt - dec;
        ovf   = pop & (after == DEPTH_C);
        if (pop && !ovf) begin
            cdt_next = {1'b0, after + CW'(1'b1)};
        end else begin
            cdt_next = {ovf, after};
        end
    endfunction

    assign rem_s        = {1'b0, line_atoms_q} - {1'b0, atom_off_q} + 14'd1;
    assign line_end_s   = (rem_s <= 14'(MAX_BURST));
    assign size_s       = line_end_s ? rem_s[4:0] : 5'(MAX_BURST);
    assign size_m1_s    = size_s - 5'd1;
    assign last_line_s  = (line_idx_q == line_num_q);
    assign last_cube_s  = last_line_s & line_end_s;
    assign sel_cdt_s    = ram_q ? mc_cdt_q : cv_cdt_q;
    assign sel_rdy_s    = ram_q ? pdp2mcif_rd_req_ready : pdp2cvif_rd_req_ready;
    assign out_drain_s  = req_vld_q & sel_rdy_s;
    assign accept_s     = (state_q == ST_IDLE) & cmd_valid;
    assign commit_s     = (state_q == ST_ISSUE) & ~all_cmt_q & (~req_vld_q | out_drain_s)
                        & (sel_cdt_s >= CW'(size_s)) & ig2cq_prdy;
    assign burst_addr_s = line_base_q + (AW'(atom_off_q) << ASH);

    assign mc_dec_s = (commit_s & ram_q)  ? CW'(size_s) : {CW{1'b0}};
    assign cv_dec_s = (commit_s & ~ram_q) ? CW'(size_s) : {CW{1'b0}};
    assign mc_nxt_s = cdt_next(mc_cdt_q, mc_dec_s, mcif_cdt_pop);
    assign cv_nxt_s = cdt_next(cv_cdt_q, cv_dec_s, cvif_cdt_pop);

    // Next-state logic of the command walker.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (all_cmt_q && (!req_vld_q || out_drain_s)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (sel_cdt_s == DEPTH_C) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latch and line/atom walk position.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            ram_q        <= 1'b0;
            line_num_q   <= 13'd0;
            line_atoms_q <= 13'd0;
            stride_q     <= 32'd0;
            line_base_q  <= {AW{1'b0}};
            atom_off_q   <= 13'd0;
            line_idx_q   <= 13'd0;
            all_cmt_q    <= 1'b0;
        end else if (accept_s) begin
            ram_q        <= cmd_ram_type;
            line_num_q   <= cmd_line_num;
            line_atoms_q <= cmd_line_atoms;
            stride_q     <= cmd_line_stride;
            line_base_q  <= cmd_addr;
            atom_off_q   <= 13'd0;
            line_idx_q   <= 13'd0;
            all_cmt_q    <= 1'b0;
        end else if (commit_s) begin
            if (line_end_s) begin
                atom_off_q  <= 13'd0;
                line_idx_q  <= line_idx_q + 13'd1;
                line_base_q <= line_base_q + AW'(stride_q);
                all_cmt_q   <= last_cube_s;
            end else begin
                atom_off_q  <= atom_off_q + 13'(MAX_BURST);
            end
        end
    end

    // Request output register, held stable until the selected interface accepts it.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            req_vld_q <= 1'b0;
            req_pd_q  <= {(AW+15){1'b0}};
        end else if (commit_s) begin
            req_vld_q <= 1'b1;
            req_pd_q  <= {15'(size_m1_s), burst_addr_s};
        end else if (out_drain_s) begin
            req_vld_q <= 1'b0;
        end
    end

    // Per-interface latency-FIFO credits; pops are honoured in every state.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            mc_cdt_q <= DEPTH_C;
            cv_cdt_q <= DEPTH_C;
            err_q    <= 1'b0;
        end else begin
            mc_cdt_q <= mc_nxt_s[CW-1:0];
            cv_cdt_q <= cv_nxt_s[CW-1:0];
            err_q    <= err_q | mc_nxt_s[CW] | cv_nxt_s[CW];
        end
    end

    // Saturating back-pressure counter, restarted by each new command.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            perf_q <= 32'd0;
        end else if (accept_s) begin
            perf_q <= 32'd0;
        end else if (req_vld_q && !sel_rdy_s && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign cmd_ready             = (state_q == ST_IDLE);
    assign pdp2mcif_rd_req_valid = req_vld_q & ram_q;
    assign pdp2cvif_rd_req_valid = req_vld_q & ~ram_q;
    assign pdp2mcif_rd_req_pd    = ram_q ? req_pd_q : {(AW+15){1'b0}};
    assign pdp2cvif_rd_req_pd    = ram_q ? {(AW+15){1'b0}} : req_pd_q;
    assign ig2cq_pvld            = commit_s;
    assign ig2cq_pd              = commit_s ? {last_cube_s, last_line_s, size_m1_s[3:0]} : 6'd0;
    assign perf_read_stall       = perf_q;
    assign cdt_err               = err_q;
    assign done                  = (state_q == ST_DONE);

endmodule

// File: tb/tb_nv_nvdla_pdp_rdma_burst_ig.sv
// Directed bench for the PDP RDMA ingress engine: a burst model fills scoreboard
// queues at command time, a monitor pops and compares on every handshake.
module tb_nv_nvdla_pdp_rdma_burst_ig;

    localparam int AW = 64;

    logic           clk;
    logic           rst_n;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [AW-1:0]  cmd_addr;
    logic [12:0]    cmd_line_num;
    logic [12:0]    cmd_line_atoms;
    logic [31:0]    cmd_line_stride;
    logic           cmd_ram_type;
    logic           mc_valid, mc_ready, cv_valid, cv_ready;
    logic [AW+14:0] mc_pd, cv_pd;
    logic           mc_pop, cv_pop, mc_pop_auto, cv_pop_auto, mc_pop_extra;
    logic           cq_pvld, cq_prdy;
    logic [5:0]     cq_pd;
    logic [31:0]    perf;
    logic           cdt_err, done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int mc_acc = 0, mc_popped = 0, cv_acc = 0, cv_popped = 0;
    int mc_lim = 1000000;
    logic [AW+14:0] exp_mc[$];
    logic [AW+14:0] exp_cv[$];
    logic [5:0]     exp_cq[$];

    assign mc_pop = mc_pop_auto | mc_pop_extra;
    assign cv_pop = cv_pop_auto;

    nv_nvdla_pdp_rdma_burst_ig #(.AW(AW), .MAX_BURST(8), .ATOM_BYTES(32), .LAT_FIFO_DEPTH(16)) dut (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_line_num(cmd_line_num), .cmd_line_atoms(cmd_line_atoms),
        .cmd_line_stride(cmd_line_stride), .cmd_ram_type(cmd_ram_type),
        .pdp2mcif_rd_req_valid(mc_valid), .pdp2mcif_rd_req_ready(mc_ready), .pdp2mcif_rd_req_pd(mc_pd),
        .pdp2cvif_rd_req_valid(cv_valid), .pdp2cvif_rd_req_ready(cv_ready), .pdp2cvif_rd_req_pd(cv_pd),
        .mcif_cdt_pop(mc_pop), .cvif_cdt_pop(cv_pop),
        .ig2cq_pvld(cq_pvld), .ig2cq_prdy(cq_prdy), .ig2cq_pd(cq_pd),
        .perf_read_stall(perf), .cdt_err(cdt_err), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Burst model: split each line into chunks of at most 8 atoms of 32 bytes.
    task automatic push_cmd(input logic [AW-1:0] addr, input int ln, input int la,
                            input logic [31:0] stride, input logic ram);
        logic [AW-1:0] base;
        int rem, off, sz;
        base = addr;
        for (int l = 0; l <= ln; l++) begin
            rem = la + 1;
            off = 0;
            while (rem > 0) begin
                sz = (rem > 8) ? 8 : rem;
                if (ram) exp_mc.push_back({15'(sz - 1), base + AW'(off) * 64'd32});
                else     exp_cv.push_back({15'(sz - 1), base + AW'(off) * 64'd32});
                exp_cq.push_back({(l == ln) && (rem == sz), l == ln, 4'(sz - 1)});
                off += sz;
                rem -= sz;
            end
            base = base + {32'd0, stride};
        end
    endtask

    task automatic send_cmd(input string tag, input logic [AW-1:0] addr, input int ln, input int la,
                            input logic [31:0] stride, input logic ram);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        push_cmd(addr, ln, la, stride, ram);
        cmd_addr        = addr;
        cmd_line_num    = 13'(ln);
        cmd_line_atoms  = 13'(la);
        cmd_line_stride = stride;
        cmd_ram_type    = ram;
        cmd_valid       = 1'b1;
        step(1);
        cmd_valid       = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        exp_done++;
        chk({tag, "_done_seen"}, seen, 1'b1);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, done, 1'b0);
        chk({tag, "_mc_queue_empty"}, exp_mc.size(), 0);
        chk({tag, "_cv_queue_empty"}, exp_cv.size(), 0);
        chk({tag, "_cq_queue_empty"}, exp_cq.size(), 0);
        step(1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk({tag, "_mc_valid"}, mc_valid, 1'b0);
        chk({tag, "_cv_valid"}, cv_valid, 1'b0);
        chk({tag, "_mc_pd"}, mc_pd, 79'd0);
        chk({tag, "_cv_pd"}, cv_pd, 79'd0);
        chk({tag, "_cq_pvld"}, cq_pvld, 1'b0);
        chk({tag, "_cq_pd"}, cq_pd, 6'd0);
        chk({tag, "_perf"}, perf, 32'd0);
        chk({tag, "_cdt_err"}, cdt_err, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    // Scoreboard monitor: compare every accepted request and context push against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mc_valid) chk("one_hot_valid", cv_valid, 1'b0);
            if (mc_valid && mc_ready) begin
                if (exp_mc.size() == 0) chk("mc_unexpected_req", 1'b1, 1'b0);
                else chk("mc_req_pd", mc_pd, exp_mc.pop_front());
            end
            if (cv_valid && cv_ready) begin
                if (exp_cv.size() == 0) chk("cv_unexpected_req", 1'b1, 1'b0);
                else chk("cv_req_pd", cv_pd, exp_cv.pop_front());
            end
            if (cq_pvld && cq_prdy) begin
                if (exp_cq.size() == 0) chk("cq_unexpected_push", 1'b1, 1'b0);
                else chk("cq_pd", cq_pd, exp_cq.pop_front());
            end
            if (done) done_cnt++;
        end
    end

    // Credit return model: one pop per cycle per atom accepted by memory, capped by mc_lim.
    initial begin
        mc_pop_auto = 1'b0;
        cv_pop_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mc_acc = 0; mc_popped = 0; cv_acc = 0; cv_popped = 0;
            end else begin
                if (mc_valid && mc_ready) mc_acc += int'(mc_pd[AW+14:AW]) + 1;
                if (cv_valid && cv_ready) cv_acc += int'(cv_pd[AW+14:AW]) + 1;
            end
            @(posedge clk);
            #1;
            if (rst_n && mc_popped < mc_acc && mc_popped < mc_lim) begin
                mc_pop_auto = 1'b1;
                mc_popped++;
            end else begin
                mc_pop_auto = 1'b0;
            end
            if (rst_n && cv_popped < cv_acc) begin
                cv_pop_auto = 1'b1;
                cv_popped++;
            end else begin
                cv_pop_auto = 1'b0;
            end
        end
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_line_num = 13'd0;
        cmd_line_atoms = 13'd0; cmd_line_stride = 32'd0; cmd_ram_type = 1'b0;
        mc_ready = 1'b1; cv_ready = 1'b1; cq_prdy = 1'b1; mc_pop_extra = 1'b0;
        step(3);
        @(negedge clk);
        chk_reset_outputs("reset");
        step(1);
        rst_n = 1'b1;
        step(2);

        // Single 20-atom MCIF line: 8/8/4 with first request two cycles after accept.
        send_cmd("t1", 64'h1000, 0, 19, 32'd0, 1'b1);
        @(negedge clk);
        chk("t1_commit_cycle_pvld", cq_pvld, 1'b1);
        chk("t1_latency_cycle1_valid", mc_valid, 1'b0);
        @(negedge clk);
        chk("t1_latency_cycle2_valid", mc_valid, 1'b1);
        wait_done("t1", 200);

        // Three strided lines of four atoms; last_line on the final one.
        send_cmd("t2", 64'h1000, 2, 3, 32'h400, 1'b1);
        wait_done("t2", 200);

        // Credit stall with a 16-atom FIFO.
        mc_lim = mc_popped;
        send_cmd("t3", 64'h3000, 0, 19, 32'd0, 1'b1);
        step(30);
        chk("t3_stall_mc_left", exp_mc.size(), 1);
        chk("t3_stall_cq_left", exp_cq.size(), 1);
        mc_lim = mc_popped + 4;
        step(15);
        chk("t3_after4_mc_left", exp_mc.size(), 0);
        chk("t3_after4_cq_left", exp_cq.size(), 0);
        mc_lim = mc_popped + 15;
        step(30);
        chk("t3_drain_hold_ready", cmd_ready, 1'b0);
        chk("t3_no_early_done", done_cnt, exp_done);
        mc_lim = 1000000;
        wait_done("t3", 50);

        // CVIF back-pressure for five cycles.
        cv_ready = 1'b0;
        send_cmd("t4", 64'h2000, 0, 3, 32'd0, 1'b0);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (cv_valid) seen = 1'b1;
            end
            chk("t4_cv_valid_seen", seen, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("t4_cv_valid_held", cv_valid, 1'b1);
            chk("t4_cv_pd_stable", cv_pd, {15'd3, 64'h2000});
            chk("t4_mc_valid_low", mc_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        cv_ready = 1'b1;
        wait_done("t4", 100);
        chk("t4_perf_stall", perf, 32'd5);

        // Address wrap at the top of the address space.
        send_cmd("t5", 64'hFFFF_FFFF_FFFF_FFE0, 1, 0, 32'd32, 1'b1);
        wait_done("t5", 100);

        // Asynchronous reset mid-ISSUE, then credit overflow.
        mc_ready = 1'b0;
        send_cmd("t6", 64'h5000, 3, 19, 32'h1000, 1'b1);
        step(6);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_midreset");
        exp_mc.delete();
        exp_cv.delete();
        exp_cq.delete();
        step(1);
        mc_ready = 1'b1;
        step(1);
        rst_n = 1'b1;
        step(2);
        mc_pop_extra = 1'b1;
        step(1);
        mc_pop_extra = 1'b0;
        @(negedge clk);
        chk("t6_cdt_err_set", cdt_err, 1'b1);
        step(5);
        chk("t6_cdt_err_sticky", cdt_err, 1'b1);
        chk("t6_no_done_after_reset", done_cnt, exp_done);
        send_cmd("t7", 64'h6000, 0, 0, 32'd0, 1'b1);
        wait_done("t7", 100);
        chk("t7_cdt_err_still_set", cdt_err, 1'b1);
        chk("total_done_pulses", done_cnt, exp_done);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
